// File: rtl/synapse_integrator_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : synapse_integrator_if                              |
// | Description : Bus bundle between the spike/weight source and the |
// |               synapse integrator.                                |
// |   en        - integrate enable (source -> integrator)            |
// |   spike_in  - presynaptic spike lines, one bit per input         |
// |   w_we      - weight write strobe                                |
// |   w_addr    - weight index                                       |
// |   w_data    - weight value                                       |
// |   current   - registered synaptic current (integrator -> neuron) |
// |   sat       - high for a cycle whose update clipped at 255       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface synapse_integrator_if #(
   parameter int N_IN     = 4,
   parameter int WEIGHT_W = 6
);
   logic                en;
   logic [N_IN-1:0]     spike_in;
   logic                w_we;
   logic [1:0]          w_addr;
   logic [WEIGHT_W-1:0] w_data;
   logic [7:0]          current;
   logic                sat;

   modport master (
      output en, spike_in, w_we, w_addr, w_data,
      input  current, sat
   );

   modport slave (
      input  en, spike_in, w_we, w_addr, w_data,
      output current, sat
   );
endinterface
`default_nettype wire

// File: rtl/synapse_integrator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : synapse_integrator                                 |
// | Description : Leaky synaptic current register feeding the LIF    |
// |               neuron. Each enabled cycle the current decays by   |
// |               ceil(cur / 2^DECAY_SHIFT) and the weights of the   |
// |               spiking inputs are added, saturating at 255.       |
// | Ports       :                                                    |
// |   clk       - system clock, rising edge                          |
// |   rst_n     - asynchronous active-low reset                      |
// |   bus       - synapse_integrator_if.slave (en, spike_in, w_we,   |
// |               w_addr, w_data in; current, sat out)               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module synapse_integrator #(
   parameter int N_IN        = 4,
   parameter int WEIGHT_W    = 6,
   parameter int DECAY_SHIFT = 1,
   parameter int W_RESET     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   synapse_integrator_if.slave   bus
);

   // 10 bits hold cur (255) plus the largest weight sum with room to spare.
   localparam int                C_RAW_W = 10;
   localparam logic [C_RAW_W-1:0] C_ROUND = C_RAW_W'((1 << DECAY_SHIFT) - 1);
   localparam logic [C_RAW_W-1:0] C_MAX   = C_RAW_W'(255);

   logic [WEIGHT_W-1:0] weight_q [N_IN];
   logic [7:0]          current_q, current_d;
   logic                sat_q, sat_d;

   logic [C_RAW_W-1:0]  w_sum;
   logic [C_RAW_W-1:0]  w_decay;
   logic [C_RAW_W-1:0]  w_raw;

   // Weight bank. The update below reads weight_q, so a write landing on
   // the same edge as a spike is only seen from the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            weight_q[i] <= WEIGHT_W'(W_RESET);
         end
      end else if (bus.w_we) begin
         for (int i = 0; i < N_IN; i++) begin
            if (bus.w_addr == 2'(i)) begin
               weight_q[i] <= bus.w_data;
            end
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (bus.spike_in[i]) begin
            w_sum = w_sum + C_RAW_W'(weight_q[i]);
         end
      end
   end

   // Ceiling division keeps a non-zero current decaying until it hits 0;
   // it also guarantees decay <= cur, so the subtraction never wraps.
   always_comb begin
      w_decay = ({2'b00, current_q} + C_ROUND) >> DECAY_SHIFT;
      w_raw   = {2'b00, current_q} - w_decay + w_sum;
   end

   always_comb begin
      current_d = current_q;
      sat_d     = sat_q;
      if (bus.en) begin
         if (w_raw > C_MAX) begin
            current_d = 8'hFF;
            sat_d     = 1'b1;
         end else begin
            current_d = w_raw[7:0];
            sat_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current_q <= 8'h00;
         sat_q     <= 1'b0;
      end else begin
         current_q <= current_d;
         sat_q     <= sat_d;
      end
   end

   assign bus.current = current_q;
   assign bus.sat     = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_synapse_integrator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_synapse_integrator                              |
// | Description : Self-checking bench for synapse_integrator. A      |
// |               behavioural integer model tracks current, sat and  |
// |               the weights; directed scenarios are followed by    |
// |               randomized traffic.                                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_synapse_integrator;

   localparam int C_N_IN  = 4;
   localparam int C_WW    = 6;
   localparam int C_SHIFT = 1;
   localparam int C_WRST  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   synapse_integrator_if #(.N_IN(C_N_IN), .WEIGHT_W(C_WW)) bus ();

   synapse_integrator #(
      .N_IN        (C_N_IN),
      .WEIGHT_W    (C_WW),
      .DECAY_SHIFT (C_SHIFT),
      .W_RESET     (C_WRST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int r_checks   = 0;
   int r_failures = 0;

   // Reference state
   int m_cur;
   int m_sat;
   int m_w [C_N_IN];

   task automatic chk_eq(input string tag, input int obs, input int exp);
      r_checks++;
      if (obs !== exp) begin
         r_failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cur = 0;
      m_sat = 0;
      for (int i = 0; i < C_N_IN; i++) m_w[i] = C_WRST;
   endtask

   // One clock: drive inputs, advance the model at the edge, check after it.
   task automatic cycle(input string tag, input logic e, input logic [3:0] s,
                        input logic we, input logic [1:0] a, input logic [5:0] d);
      int sum, decay, raw, div;
      bus.en       = e;
      bus.spike_in = s;
      bus.w_we     = we;
      bus.w_addr   = a;
      bus.w_data   = d;
      @(posedge clk);
      if (e) begin
         div = 1 << C_SHIFT;
         sum = 0;
         for (int i = 0; i < C_N_IN; i++) if (s[i]) sum += m_w[i];
         decay = (m_cur + div - 1) / div;
         raw   = m_cur - decay + sum;
         m_sat = (raw > 255) ? 1 : 0;
         m_cur = (raw > 255) ? 255 : raw;
      end
      if (we) m_w[a] = int'(d);
      #1;
      chk_eq({tag, ".current"}, int'(bus.current), m_cur);
      chk_eq({tag, ".sat"}, int'(bus.sat), m_sat);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [5:0] d);
      cycle("wr", 1'b0, 4'b0000, 1'b1, a, d);
   endtask

   int exp1 [6] = '{8, 4, 2, 1, 0, 0};
   int exp2 [7] = '{63, 31, 15, 7, 3, 1, 0};

   initial begin
      bus.en = 1'b0; bus.spike_in = '0; bus.w_we = 1'b0;
      bus.w_addr = 2'd0; bus.w_data = '0;
      model_reset();
      #12;
      chk_eq("reset.current", int'(bus.current), 0);
      chk_eq("reset.sat", int'(bus.sat), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single pulse on input 0 with default weight
      cycle("t1", 1'b1, 4'b0001, 1'b0, 2'd0, 6'd0);
      chk_eq("t1.seq", int'(bus.current), exp1[0]);
      for (int k = 1; k < 6; k++) begin
         idle("t1", 1);
         chk_eq("t1.seq", int'(bus.current), exp1[k]);
      end

      // 2: programmed weight
      wr(2'd2, 6'd63);
      cycle("t2", 1'b1, 4'b0100, 1'b0, 2'd0, 6'd0);
      chk_eq("t2.seq", int'(bus.current), exp2[0]);
      for (int k = 1; k < 7; k++) begin
         idle("t2", 1);
         chk_eq("t2.seq", int'(bus.current), exp2[k]);
      end

      // 3: saturation
      for (int i = 0; i < 4; i++) wr(2'(i), 6'd63);
      cycle("t3", 1'b1, 4'b1111, 1'b0, 2'd0, 6'd0);
      chk_eq("t3.first", int'(bus.current), 252);
      cycle("t3", 1'b1, 4'b1111, 1'b0, 2'd0, 6'd0);
      chk_eq("t3.clip", int'(bus.current), 255);
      chk_eq("t3.satflag", int'(bus.sat), 1);
      cycle("t3", 1'b1, 4'b1111, 1'b0, 2'd0, 6'd0);
      chk_eq("t3.hold", int'(bus.current), 255);
      idle("t3", 1);
      chk_eq("t3.drop", int'(bus.current), 127);
      chk_eq("t3.satclr", int'(bus.sat), 0);
      idle("t3", 8);

      // 4: write/spike collision uses the old weight
      wr(2'd1, 6'd8);
      cycle("t4", 1'b1, 4'b0010, 1'b1, 2'd1, 6'd40);
      chk_eq("t4.old", int'(bus.current), 8);
      cycle("t4", 1'b1, 4'b0010, 1'b0, 2'd0, 6'd0);
      chk_eq("t4.new", int'(bus.current), 44);
      idle("t4", 8);

      // 5: enable gating
      wr(2'd0, 6'd20);
      cycle("t5", 1'b1, 4'b0001, 1'b0, 2'd0, 6'd0);
      for (int k = 0; k < 3; k++) begin
         cycle("t5", 1'b0, 4'b1111, 1'b0, 2'd0, 6'd0);
         chk_eq("t5.hold", int'(bus.current), 20);
      end
      idle("t5", 1);
      chk_eq("t5.resume", int'(bus.current), 10);

      // 6: asynchronous reset mid-run with a write in flight
      cycle("t6", 1'b1, 4'b1111, 1'b0, 2'd0, 6'd0);
      cycle("t6", 1'b1, 4'b1111, 1'b0, 2'd0, 6'd0);
      bus.w_we = 1'b1; bus.w_addr = 2'd3; bus.w_data = 6'd50;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_eq("t6.async_cur", int'(bus.current), 0);
      chk_eq("t6.async_sat", int'(bus.sat), 0);
      @(posedge clk);
      #1;
      chk_eq("t6.held_cur", int'(bus.current), 0);
      @(negedge clk);
      bus.w_we = 1'b0;
      rst_n = 1'b1;
      cycle("t6", 1'b1, 4'b1000, 1'b0, 2'd0, 6'd0);
      chk_eq("t6.wreset", int'(bus.current), 8);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic       e, we;
         logic [3:0] s;
         logic [1:0] a;
         logic [5:0] d;
         e  = ($urandom_range(0, 9) != 0);
         s  = 4'($urandom);
         we = ($urandom_range(0, 3) == 0);
         a  = 2'($urandom);
         d  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom);
         cycle("rand", e, s, we, a, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
      $finish;
   end

endmodule
`default_nettype wire
